// File: rtl/board_pkg.sv
// Board-level timing constants shared by the input-conditioning blocks.
package board_pkg;

  localparam int unsigned CLK_FREQ_HZ     = 100000000;
  localparam int unsigned DEBOUNCE_MS     = 10;
  localparam int unsigned DEBOUNCE_CYCLES = CLK_FREQ_HZ / 1000 * DEBOUNCE_MS;

endpackage : board_pkg

// File: rtl/sw_debounce_chan.sv
// One switch channel: 2-FF synchroniser, stability counter, clean level and edge flags.
module sw_debounce_chan #(
  parameter int unsigned STABLE_CYCLES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_raw,
  output logic sw_clean,
  output logic sw_rise,
  output logic sw_fall
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             sync_q1, sync_q1_d;
  logic             sync_q2, sync_q2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clean_q, clean_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  always_comb begin
    sync_q1_d = sw_raw;
    sync_q2_d = sync_q1;
    cnt_d     = '0;
    clean_d   = clean_q;
    rise_d    = 1'b0;
    fall_d    = 1'b0;
    // Any agreement with the clean level restarts the count, so bounce never accumulates.
    if (sync_q2 != clean_q) begin
      if (cnt_q == CNT_TC) begin
        clean_d = sync_q2;
        rise_d  = sync_q2;
        fall_d  = ~sync_q2;
      end else begin
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      cnt_q   <= '0;
      clean_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q1 <= sync_q1_d;
      sync_q2 <= sync_q2_d;
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign sw_clean = clean_q;
  assign sw_rise  = rise_q;
  assign sw_fall  = fall_q;

endmodule : sw_debounce_chan

// File: rtl/sw_debounce.sv
// Slide-switch conditioner: WIDTH independent debounce channels with clean levels and edge pulses.
module sw_debounce
  import board_pkg::*;
#(
  parameter int unsigned WIDTH         = 4,
  parameter int unsigned STABLE_CYCLES = DEBOUNCE_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    sw_debounce_chan #(
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .sw_raw  (sw_raw[i]),
      .sw_clean(sw_clean[i]),
      .sw_rise (sw_rise[i]),
      .sw_fall (sw_fall[i])
    );
  end

endmodule : sw_debounce

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce with STABLE_CYCLES=8, WIDTH=4.
module tb_sw_debounce;

  logic       clk;
  logic       rst_n;
  logic [3:0] sw_raw;
  logic [3:0] sw_clean;
  logic [3:0] sw_rise;
  logic [3:0] sw_fall;

  int vectors = 0;
  int errors  = 0;

  sw_debounce #(
    .WIDTH        (4),
    .STABLE_CYCLES(8)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .sw_raw  (sw_raw),
    .sw_clean(sw_clean),
    .sw_rise (sw_rise),
    .sw_fall (sw_fall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] c, input logic [3:0] r,
                         input logic [3:0] f);
    chk({tag, ".clean"}, sw_clean, c);
    chk({tag, ".rise"},  sw_rise,  r);
    chk({tag, ".fall"},  sw_fall,  f);
  endtask

  // Advance n rising edges, landing 1 time unit after the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n  = 1'b0;
    sw_raw = 4'b1111;

    // 1. Reset held with all switches high.
    tick(1);
    for (int i = 0; i < 5; i++) begin
      chk_all("rst_hold", 4'b0000, 4'b0000, 4'b0000);
      tick(1);
    end
    sw_raw = 4'b0000;
    tick(1);
    rst_n = 1'b1;
    tick(3);
    chk_all("post_rst", 4'b0000, 4'b0000, 4'b0000);

    // 2. Single clean rise on bit 3.
    sw_raw[3] = 1'b1;
    tick(9);
    chk_all("t2_e9", 4'b0000, 4'b0000, 4'b0000);
    tick(1);
    chk_all("t2_e10", 4'b1000, 4'b1000, 4'b0000);
    tick(1);
    chk_all("t2_e11", 4'b1000, 4'b0000, 4'b0000);

    // 3. Bit 1 bouncing every 3 cycles, then held high.
    for (int t = 0; t < 10; t++) begin
      sw_raw[1] = ~sw_raw[1];
      for (int k = 0; k < 3; k++) begin
        tick(1);
        chk_all("t3_bounce", 4'b1000, 4'b0000, 4'b0000);
      end
    end
    sw_raw[1] = 1'b1;
    tick(9);
    chk_all("t3_e9", 4'b1000, 4'b0000, 4'b0000);
    tick(1);
    chk_all("t3_e10", 4'b1010, 4'b0010, 4'b0000);
    for (int k = 0; k < 4; k++) begin
      tick(1);
      chk_all("t3_hold", 4'b1010, 4'b0000, 4'b0000);
    end

    // Return to all-low before the glitch tests.
    sw_raw = 4'b0000;
    tick(10);
    chk_all("clr_e10", 4'b0000, 4'b0000, 4'b1010);
    tick(2);

    // 4a. 7-cycle glitch on bit 0 is rejected.
    sw_raw[0] = 1'b1;
    tick(7);
    sw_raw[0] = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick(1);
      chk_all("t4_glitch7", 4'b0000, 4'b0000, 4'b0000);
    end

    // 4b. 8-cycle pulse on bit 0 is accepted, then released.
    sw_raw[0] = 1'b1;
    tick(8);
    sw_raw[0] = 1'b0;
    tick(1);
    chk_all("t4_e9", 4'b0000, 4'b0000, 4'b0000);
    tick(1);
    chk_all("t4_e10", 4'b0001, 4'b0001, 4'b0000);
    tick(7);
    chk_all("t4_e17", 4'b0001, 4'b0000, 4'b0000);
    tick(1);
    chk_all("t4_e18", 4'b0000, 4'b0000, 4'b0001);
    tick(1);
    chk_all("t4_e19", 4'b0000, 4'b0000, 4'b0000);

    // 5. Simultaneous rise on bit 3 and fall on bit 2.
    sw_raw[2] = 1'b1;
    tick(10);
    chk_all("t5_setup", 4'b0100, 4'b0100, 4'b0000);
    tick(2);
    sw_raw = 4'b1000;
    tick(9);
    chk_all("t5_e9", 4'b0100, 4'b0000, 4'b0000);
    tick(1);
    chk_all("t5_e10", 4'b1000, 4'b1000, 4'b0100);
    tick(1);
    chk_all("t5_e11", 4'b1000, 4'b0000, 4'b0000);

    // 6. Reset mid-count with bit 0 held high; reset asserts between edges.
    sw_raw = 4'b0001;
    tick(5);
    chk("t6_pre_rst", sw_clean, 4'b1000);
    rst_n = 1'b0;
    #1;
    chk_all("t6_async_clr", 4'b0000, 4'b0000, 4'b0000);
    tick(3);
    chk_all("t6_in_rst", 4'b0000, 4'b0000, 4'b0000);
    rst_n = 1'b1;
    tick(9);
    chk_all("t6_e9", 4'b0000, 4'b0000, 4'b0000);
    tick(1);
    chk_all("t6_e10", 4'b0001, 4'b0001, 4'b0000);
    tick(1);
    chk_all("t6_e11", 4'b0001, 4'b0000, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule : tb_sw_debounce
